// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the two-byte UART debug command master: opcodes,
// FSM states, response error codes and the reply-expecting opcode test.
package uart_cmd_pkg;

  localparam logic [7:0] OP_ILLEGAL = 8'h00;
  localparam logic [7:0] OP_CLK_HI  = 8'h10;
  localparam logic [7:0] OP_CLK_LO  = 8'h11;
  localparam logic [7:0] OP_RST_HI  = 8'h12;
  localparam logic [7:0] OP_RST_LO  = 8'h13;
  localparam logic [7:0] OP_PIN_RD  = 8'h20;
  localparam logic [7:0] OP_PIN_WR  = 8'h30;
  localparam logic [7:0] OP_REG_WR  = 8'h40;
  localparam logic [7:0] OP_REG_RD  = 8'h50;
  localparam logic [7:0] OP_SDR_WR  = 8'hA0;
  localparam logic [7:0] OP_SDR_RD  = 8'hA1;
  localparam logic [7:0] OP_SDR_WR4 = 8'hB0;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_ILLEGAL = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND_OP,
    ST_WAIT_OP,
    ST_SEND_DAT,
    ST_WAIT_DAT,
    ST_WAIT_RSP,
    ST_DONE
  } state_t;

  // Only the pin-read (0x2x) and register-read (0x5x) families answer.
  function automatic logic op_has_reply(input logic [7:0] op);
    return (op[7:4] == 4'h2) || (op[7:4] == 4'h5);
  endfunction

endpackage

// File: rtl/uart_cmd_timer.sv
// Reply-wait counter: clear has priority over load, load over increment;
// expire flags the last cycle of the allowed window.
module uart_cmd_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
  parameter int unsigned TO_W           = 20
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_clr,
  input  logic            i_load,
  input  logic [TO_W-1:0] i_load_val,
  input  logic            i_en,
  output logic            o_expire
);

  localparam logic [TO_W-1:0] EXPIRE_AT = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_expire = (r_count == EXPIRE_AT);

endmodule

// File: rtl/uart_cmd_master.sv
// Initiator for the two-byte UART debug protocol: sends op then data byte,
// optionally waits for one reply byte, and reports completion with an error code.
module uart_cmd_master
  import uart_cmd_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
  parameter int unsigned TO_W           = 20
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_op,
  input  logic [7:0] cmd_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic [1:0] rsp_err,
  output logic       tx_en,
  output logic [7:0] tx_data,
  input  logic       tx_done,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic [7:0] stray_cnt
);

  // The tx_done cycle itself counts as cycle 0 of the window, so the first
  // WAIT_RSP cycle already sits at 1.
  localparam logic [TO_W-1:0] TMR_START = TO_W'(1);

  state_t     r_state;
  logic [7:0] r_op;
  logic [7:0] r_data;
  logic       r_cmd_ready;
  logic       r_rsp_valid;
  logic [7:0] r_rsp_data;
  logic [1:0] r_rsp_err;
  logic       r_tx_en;
  logic [7:0] r_tx_data;
  logic [7:0] r_stray;

  logic w_accept;
  logic w_tmr_load;
  logic w_tmr_en;
  logic w_tmr_clr;
  logic w_expire;

  assign w_accept   = (r_state == ST_IDLE) && cmd_valid && r_cmd_ready;
  assign w_tmr_load = (r_state == ST_WAIT_DAT) && tx_done && op_has_reply(r_op);
  assign w_tmr_en   = (r_state == ST_WAIT_RSP);
  assign w_tmr_clr  = !(w_tmr_load || w_tmr_en);

  uart_cmd_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TO_W          (TO_W)
  ) u_timer (
    .i_clk     (sys_clk),
    .i_rst     (sys_rst),
    .i_clr     (w_tmr_clr),
    .i_load    (w_tmr_load),
    .i_load_val(TMR_START),
    .i_en      (w_tmr_en),
    .o_expire  (w_expire)
  );

  always_ff @(posedge sys_clk) begin
    if (w_accept) begin
      r_op   <= cmd_op;
      r_data <= cmd_data;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state     <= ST_IDLE;
      r_cmd_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= 8'h00;
      r_rsp_err   <= ERR_OK;
      r_tx_en     <= 1'b0;
      r_tx_data   <= 8'h00;
    end else begin
      r_rsp_valid <= 1'b0;
      r_tx_en     <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_cmd_ready <= 1'b1;
          if (w_accept) begin
            r_cmd_ready <= 1'b0;
            if (cmd_op == OP_ILLEGAL) begin
              r_state     <= ST_DONE;
              r_rsp_valid <= 1'b1;
              r_rsp_data  <= 8'h00;
              r_rsp_err   <= ERR_ILLEGAL;
            end else begin
              r_state   <= ST_SEND_OP;
              r_tx_en   <= 1'b1;
              r_tx_data <= cmd_op;
            end
          end
        end
        ST_SEND_OP:  r_state <= ST_WAIT_OP;
        ST_WAIT_OP: begin
          if (tx_done) begin
            r_state   <= ST_SEND_DAT;
            r_tx_en   <= 1'b1;
            r_tx_data <= r_data;
          end
        end
        ST_SEND_DAT: r_state <= ST_WAIT_DAT;
        ST_WAIT_DAT: begin
          if (tx_done) begin
            if (op_has_reply(r_op)) begin
              r_state <= ST_WAIT_RSP;
            end else begin
              r_state     <= ST_DONE;
              r_rsp_valid <= 1'b1;
              r_rsp_data  <= 8'h00;
              r_rsp_err   <= ERR_OK;
            end
          end
        end
        ST_WAIT_RSP: begin
          // A reply landing on the expiry cycle still counts as a reply.
          if (rx_valid) begin
            r_state     <= ST_DONE;
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= rx_data;
            r_rsp_err   <= ERR_OK;
          end else if (w_expire) begin
            r_state     <= ST_DONE;
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= 8'h00;
            r_rsp_err   <= ERR_TIMEOUT;
          end
        end
        ST_DONE: begin
          r_state     <= ST_IDLE;
          r_cmd_ready <= 1'b1;
          r_rsp_data  <= 8'h00;
          r_rsp_err   <= ERR_OK;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_stray <= 8'h00;
    end else if (rx_valid && (r_state != ST_WAIT_RSP) && (r_stray != 8'hFF)) begin
      r_stray <= r_stray + 8'h01;
    end
  end

  assign cmd_ready = r_cmd_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_err   = r_rsp_err;
  assign tx_en     = r_tx_en;
  assign tx_data   = r_tx_data;
  assign stray_cnt = r_stray;

endmodule

// File: tb/tb_uart_cmd_master.sv
// Directed bench for uart_cmd_master: a byte-level UART stand-in plus a
// queue-based expectation model checked every cycle.
module tb_uart_cmd_master;

  localparam int TO = 16;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [7:0] cmd_op = 8'h00;
  logic [7:0] cmd_data = 8'h00;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic [1:0] rsp_err;
  logic       tx_en;
  logic [7:0] tx_data;
  logic       tx_done = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic [7:0] stray_cnt;
  logic       rx_is_reply = 1'b0;

  always #5 sys_clk = ~sys_clk;

  uart_cmd_master #(.TIMEOUT_CYCLES(TO), .TO_W(20)) dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op   (cmd_op),
    .cmd_data (cmd_data),
    .rsp_valid(rsp_valid),
    .rsp_data (rsp_data),
    .rsp_err  (rsp_err),
    .tx_en    (tx_en),
    .tx_data  (tx_data),
    .tx_done  (tx_done),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .stray_cnt(stray_cnt)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expectation model: bytes that must appear on tx, responses that must be
  // reported, and the stray counter derived from what the stimulus intended.
  logic [7:0] exp_tx[$];
  logic [9:0] exp_rsp[$];
  int         exp_stray = 0;
  logic [7:0] last_tx = 8'h00;
  logic [7:0] last_rsp_data = 8'h00;
  logic [1:0] last_rsp_err = 2'b00;
  int         rsp_cnt = 0;
  int         rsp_cyc = 0;

  always @(posedge sys_clk) begin
    if (sys_rst) exp_stray = 0;
    else if (rx_valid && !rx_is_reply && exp_stray < 255) exp_stray = exp_stray + 1;
  end

  always @(negedge sys_clk) begin
    chk("stray_cnt", {24'h0, stray_cnt}, exp_stray);
    if (tx_en) begin
      if (exp_tx.size() == 0) chk("tx_en_unexpected", {31'h0, tx_en}, 0);
      else chk("tx_byte", {24'h0, tx_data}, {24'h0, exp_tx.pop_front()});
      last_tx = tx_data;
    end
    if (tx_done) chk("tx_data_hold", {24'h0, tx_data}, {24'h0, last_tx});
    if (rsp_valid) begin
      if (exp_rsp.size() == 0) begin
        chk("rsp_valid_unexpected", {31'h0, rsp_valid}, 0);
      end else begin
        logic [9:0] e;
        e = exp_rsp.pop_front();
        chk("rsp_err", {30'h0, rsp_err}, {30'h0, e[9:8]});
        chk("rsp_data", {24'h0, rsp_data}, {24'h0, e[7:0]});
      end
      last_rsp_data = rsp_data;
      last_rsp_err  = rsp_err;
      rsp_cnt++;
      rsp_cyc = cyc;
    end
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  int accept_cyc = 0;
  int tdone_cyc = 0;

  task automatic accept_cmd(input logic [7:0] op, input logic [7:0] data);
    int w;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    w = 0;
    while (!cmd_ready && w < 100) begin
      tick();
      w++;
    end
    chk("cmd_ready_wait", {31'h0, cmd_ready}, 1);
    accept_cyc = cyc;
    tick();
    cmd_valid = 1'b0;
    cmd_op    = 8'hEE;
    cmd_data  = 8'hEE;
  endtask

  task automatic serve_tx_byte();
    int w;
    w = 0;
    while (!tx_en && w < 100) begin
      tick();
      w++;
    end
    chk("tx_en_wait", {31'h0, tx_en}, 1);
    repeat (10) tick();
    tx_done   = 1'b1;
    tdone_cyc = cyc;
    tick();
    tx_done   = 1'b0;
  endtask

  task automatic pulse_rx(input logic [7:0] b, input logic is_reply);
    rx_valid    = 1'b1;
    rx_data     = b;
    rx_is_reply = is_reply;
    tick();
    rx_valid    = 1'b0;
    rx_is_reply = 1'b0;
  endtask

  // reply_delay: cycles from the data byte's tx_done to rx_valid; 0 = never.
  task automatic run_cmd(input logic [7:0] op, input logic [7:0] data,
                         input int reply_delay, input logic [7:0] reply);
    logic [9:0] e;
    int start;
    int w;
    if (op == 8'h00) begin
      e = {2'b10, 8'h00};
    end else begin
      exp_tx.push_back(op);
      exp_tx.push_back(data);
      if (op[7:4] == 4'h2 || op[7:4] == 4'h5)
        e = (reply_delay >= 1 && reply_delay <= TO - 1) ? {2'b00, reply} : {2'b01, 8'h00};
      else
        e = {2'b00, 8'h00};
    end
    exp_rsp.push_back(e);
    start = rsp_cnt;
    accept_cmd(op, data);
    if (op != 8'h00) begin
      serve_tx_byte();
      serve_tx_byte();
      if (reply_delay > 0) begin
        repeat (reply_delay - 1) tick();
        pulse_rx(reply, 1'b1);
      end
    end
    w = 0;
    while (rsp_cnt == start && w < TO + 50) begin
      tick();
      w++;
    end
    chk("rsp_wait", rsp_cnt, start + 1);
  endtask

  initial begin
    int saved;
    // Reset state
    tick();
    tick();
    chk("rst_cmd_ready", {31'h0, cmd_ready}, 0);
    chk("rst_rsp_valid", {31'h0, rsp_valid}, 0);
    chk("rst_rsp_data", {24'h0, rsp_data}, 0);
    chk("rst_rsp_err", {30'h0, rsp_err}, 0);
    chk("rst_tx_en", {31'h0, tx_en}, 0);
    chk("rst_tx_data", {24'h0, tx_data}, 0);
    chk("rst_stray", {24'h0, stray_cnt}, 0);
    sys_rst = 1'b0;
    tick();
    chk("post_rst_cmd_ready", {31'h0, cmd_ready}, 1);

    // Write 0x31/0xA5: completes the cycle after the data byte's tx_done
    run_cmd(8'h31, 8'hA5, 0, 8'h00);
    chk("wr_latency", rsp_cyc - tdone_cyc, 1);
    chk("wr_err_lit", {30'h0, last_rsp_err}, 0);

    // Read 0x52, reply 0x3C after 7 cycles
    run_cmd(8'h52, 8'h00, 7, 8'h3C);
    chk("rd_data_lit", {24'h0, last_rsp_data}, 32'h3C);
    chk("rd_stray_lit", {24'h0, stray_cnt}, 0);

    // Read 0x21 with no reply: timeout exactly TO cycles after tx_done
    run_cmd(8'h21, 8'h00, 0, 8'h00);
    chk("to_latency", rsp_cyc - tdone_cyc, 16);
    chk("to_err_lit", {30'h0, last_rsp_err}, 1);
    tick();
    tick();
    pulse_rx(8'h77, 1'b0);
    tick();
    chk("late_reply_stray_lit", {24'h0, stray_cnt}, 1);

    // Illegal op: no tx, err=10 within 2 cycles
    run_cmd(8'h00, 8'h5A, 0, 8'h00);
    chk("illegal_latency_le2", {31'h0, (rsp_cyc - accept_cyc) <= 2}, 1);
    chk("illegal_err_lit", {30'h0, last_rsp_err}, 2);
    tick();
    for (int i = 0; i < 300; i++) begin
      pulse_rx(i[7:0], 1'b0);
      tick();
    end
    chk("stray_sat_lit", {24'h0, stray_cnt}, 32'hFF);

    // Register read, reply on the first waiting cycle
    run_cmd(8'h57, 8'h11, 1, 8'h81);
    chk("rd_fast_data_lit", {24'h0, last_rsp_data}, 32'h81);

    // Reset during WAIT_OP of write 0x40: command abandoned, no response
    exp_tx.push_back(8'h40);
    saved = rsp_cnt;
    accept_cmd(8'h40, 8'h12);
    repeat (3) tick();
    sys_rst = 1'b1;
    tick();
    exp_tx.delete();
    chk("mid_rst_cmd_ready", {31'h0, cmd_ready}, 0);
    chk("mid_rst_tx_en", {31'h0, tx_en}, 0);
    chk("mid_rst_tx_data", {24'h0, tx_data}, 0);
    chk("mid_rst_rsp_valid", {31'h0, rsp_valid}, 0);
    chk("mid_rst_rsp_data", {24'h0, rsp_data}, 0);
    chk("mid_rst_rsp_err", {30'h0, rsp_err}, 0);
    chk("mid_rst_stray", {24'h0, stray_cnt}, 0);
    sys_rst = 1'b0;
    repeat (30) tick();
    chk("no_rsp_after_rst", rsp_cnt, saved);

    // Read 0x50 with reply on the final cycle of the window: reply wins
    run_cmd(8'h50, 8'h00, TO - 1, 8'h9E);
    chk("edge_err_lit", {30'h0, last_rsp_err}, 0);
    chk("edge_data_lit", {24'h0, last_rsp_data}, 32'h9E);

    repeat (5) tick();
    chk("tx_queue_drained", exp_tx.size(), 0);
    chk("rsp_queue_drained", exp_rsp.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
